lcd_timing_gen: RTL and testbench
=================================

Name: lcd_timing_gen

Overview:
Parametrised successor to the fixed 480x272 LCD timing controller. Generates DCLK, HSYNC, VSYNC, DE and DISP for a parallel-RGB TFT, with configurable porch/sync geometry, clock divide, sync polarities and SYNC/DE mode. Drives a linear frame-buffer read address to the SRAM controller. Adds a run/stop control that always stops at a frame boundary.

Parameters:
H_SYNC, 1, HSYNC width in pixel clocks
H_BP, 42, horizontal back porch after sync
H_ACTIVE, 480, visible pixels per line
H_FP, 8, horizontal front porch (H_TOTAL = sum = 531)
V_SYNC, 10, VSYNC width in lines
V_BP, 2, vertical back porch
V_ACTIVE, 272, visible lines
V_FP, 4, vertical front porch (V_TOTAL = 288)
CLK_DIV, 4, i_clk cycles per pixel clock; even, >= 2
HS_POL, 0, HSYNC active level
VS_POL, 0, VSYNC active level
DE_MODE, 0, 0 = SYNC mode (o_de held 0), 1 = DE mode
ADDR_W, 17, read address width; must hold H_ACTIVE*V_ACTIVE

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_en  in  1  run request; level-sensitive
o_dclk  out  1  panel pixel clock
o_hsync  out  1  horizontal sync
o_vsync  out  1  vertical sync
o_de  out  1  data enable
o_disp  out  1  panel display-on
o_pix_active  out  1  current pixel is visible (independent of DE_MODE)
o_raddr  out  ADDR_W  frame-buffer read address
o_raddr_max  out  ADDR_W  constant H_ACTIVE*V_ACTIVE
o_disp_width  out  16  constant H_ACTIVE
o_frame_start  out  1  one-i_clk pulse at position (0,0)
o_busy  out  1  state != IDLE

Behaviour:
- States: IDLE, RUN, STOPPING. Reset -> IDLE.
- Reset/IDLE outputs: o_dclk=0, o_hsync=~HS_POL, o_vsync=~VS_POL, o_de=0, o_disp=0, o_pix_active=0, o_raddr=0, o_frame_start=0, o_busy=0; div_cnt=0, h=0, v=0.
- IDLE -> RUN when i_en=1. First RUN cycle presents position (0,0) with div_cnt=0 and o_frame_start=1.
- div_cnt counts 0..CLK_DIV-1 and wraps. Pixel tick = div_cnt==CLK_DIV-1. o_dclk=1 exactly while div_cnt >= CLK_DIV/2. Timing outputs change only when div_cnt returns to 0 (dclk low); the panel samples on the dclk rising edge, mid-pixel.
- On a tick, h increments. At H_TOTAL-1, h wraps to 0 and v increments. At (H_TOTAL-1, V_TOTAL-1), v wraps to 0.
- All outputs are registered and consistent with the current (h,v):
  - hsync active when h < H_SYNC.
  - vsync active when v < V_SYNC.
  - Visible when h is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - o_pix_active = visible. o_de = visible if DE_MODE=1, else 0.
  - o_disp=1 in RUN and STOPPING.
- o_raddr: equals the number of visible pixels already presented in the frame, so visible pixel k (raster order) shows k. It increments when a visible pixel ends, and holds otherwise. It is forced to 0 on entry to (0,0). Last visible pixel = H_ACTIVE*V_ACTIVE-1, and it never exceeds o_raddr_max.
- o_frame_start: 1 for exactly one i_clk on each entry to (0,0) with div_cnt=0.
- RUN with i_en=0 -> STOPPING. Timing continues unchanged.
- STOPPING with i_en=1 -> RUN. No glitch and no restart.
- STOPPING at the tick ending (H_TOTAL-1, V_TOTAL-1) -> IDLE. The next cycle shows IDLE outputs, so (0,0) is not presented.
- Reset asserted mid-frame: all outputs reach reset values asynchronously. After release, the block stays IDLE until i_en=1.

Decomposition:
- Package lcd_timing_pkg: state enum (IDLE/RUN/STOPPING) and a derived-constant function set (H_TOTAL, V_TOTAL, visible start/end).
- One natural sub-module, lcd_pix_clk_div: div_cnt, tick and dclk generation, with run/clear inputs.
- Position counters, state machine and output decode stay in the top.

Test Plan:
- Defaults: assert i_rst, then i_en=1 -> IDLE values during reset. o_frame_start first pulses 1 cycle after i_en is sampled. o_dclk period is 4 cycles (2 low, 2 high).
- Defaults, free run -> o_hsync low 4 cycles every 2124 cycles. o_vsync low 10*2124 cycles per 611712-cycle frame. o_frame_start period 611712. o_de stays 0.
- Defaults -> o_raddr=0 at first visible pixel (h=43,v=12), 479 at the line's last pixel, 130559 at the final visible pixel, back to 0 at the next frame start.
- Small config (H 2/2/4/2, V 1/1/3/1, CLK_DIV=2, DE_MODE=1, HS_POL=VS_POL=1) -> o_de high 4 pixels per line on 3 lines, aligned with o_raddr 0..11. o_hsync/o_vsync high when active.
- Small config: drop i_en mid-frame -> frame completes, IDLE entered after the tick ending (9,5), o_busy falls. Re-raise i_en during STOPPING -> no gap in the next frame_start spacing (120 cycles).
- Assert i_rst mid-visible-area -> outputs reset asynchronously. Release with i_en=0 stays IDLE, then restarts cleanly at (0,0).

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared types and geometry helpers for the parallel-RGB LCD timing generator.
package lcd_timing_pkg;

  // Controller run state. IDLE holds every output at its parked value.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } lcd_state_e;

  // Full period of one axis (sync + back porch + active + front porch).
  function automatic int calc_total(input int sync_w, input int bp, input int act, input int fp);
    return sync_w + bp + act + fp;
  endfunction

  // First visible position on an axis.
  function automatic int calc_vis_start(input int sync_w, input int bp);
    return sync_w + bp;
  endfunction

  // One past the last visible position on an axis.
  function automatic int calc_vis_end(input int sync_w, input int bp, input int act);
    return sync_w + bp + act;
  endfunction

endpackage

// File: rtl/lcd_pix_clk_div.sv
// Pixel clock divider: phase counter, end-of-pixel tick and registered DCLK.
// The counter parks at 0 when not running or when cleared, so the first
// running cycle always starts a fresh pixel with DCLK low.
module lcd_pix_clk_div #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_div_nxt,
  output logic             o_tick,
  output logic             o_dclk
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(CLK_DIV / 2);

  logic [CNT_W-1:0] r_div_cnt;
  logic             r_dclk;
  logic             w_tick;
  logic [CNT_W-1:0] w_div_nxt;

  // Tick on the last phase of a pixel; next phase wraps to 0 on tick or clear.
  always_comb begin
    w_tick    = i_run && (r_div_cnt == DIV_LAST);
    w_div_nxt = '0;
    if (i_run && !i_clear && !w_tick) begin
      w_div_nxt = r_div_cnt + CNT_W'(1);
    end
  end

  // Phase counter and DCLK, high during the second half of each pixel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_cnt <= '0;
      r_dclk    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_dclk    <= (w_div_nxt >= DIV_HALF);
    end
  end

  assign o_div_nxt = w_div_nxt;
  assign o_tick    = w_tick;
  assign o_dclk    = r_dclk;

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD timing generator: raster position counters, run/stop FSM
// and registered sync/DE/address decode. Every output register is loaded from
// the decode of the next (state, h, v, phase), so outputs always describe the
// position currently held in the counters.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int   H_SYNC   = 1,
  parameter int   H_BP     = 42,
  parameter int   H_ACTIVE = 480,
  parameter int   H_FP     = 8,
  parameter int   V_SYNC   = 10,
  parameter int   V_BP     = 2,
  parameter int   V_ACTIVE = 272,
  parameter int   V_FP     = 4,
  parameter int   CLK_DIV  = 4,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter bit   DE_MODE  = 1'b0,
  parameter int   ADDR_W   = 17
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  output logic              o_dclk,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic              o_disp,
  output logic              o_pix_active,
  output logic [ADDR_W-1:0] o_raddr,
  output logic [ADDR_W-1:0] o_raddr_max,
  output logic [15:0]       o_disp_width,
  output logic              o_frame_start,
  output logic              o_busy
);

  localparam int H_TOTAL = calc_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = calc_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int H_W     = $clog2(H_TOTAL + 1);
  localparam int V_W     = $clog2(V_TOTAL + 1);
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [H_W-1:0] H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_SYNC_E  = H_W'(H_SYNC);
  localparam logic [V_W-1:0] V_SYNC_E  = V_W'(V_SYNC);
  localparam logic [H_W-1:0] H_VIS_S   = H_W'(calc_vis_start(H_SYNC, H_BP));
  localparam logic [H_W-1:0] H_VIS_E   = H_W'(calc_vis_end(H_SYNC, H_BP, H_ACTIVE));
  localparam logic [V_W-1:0] V_VIS_S   = V_W'(calc_vis_start(V_SYNC, V_BP));
  localparam logic [V_W-1:0] V_VIS_E   = V_W'(calc_vis_end(V_SYNC, V_BP, V_ACTIVE));

  lcd_state_e        r_state;
  lcd_state_e        w_state_nxt;
  logic [H_W-1:0]    r_h;
  logic [H_W-1:0]    w_h_nxt;
  logic [V_W-1:0]    r_v;
  logic [V_W-1:0]    w_v_nxt;
  logic [DIV_W-1:0]  w_div_nxt;
  logic              w_tick;
  logic              w_run;
  logic              w_clear;
  logic              w_end_tick;

  logic              w_act;
  logic              w_vis;
  logic              w_fs;
  logic              w_hs_on;
  logic              w_vs_on;
  logic [ADDR_W-1:0] w_raddr_nxt;

  logic              r_hsync;
  logic              r_vsync;
  logic              r_de;
  logic              r_disp;
  logic              r_pix_active;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_frame_start;
  logic              r_busy;

  assign w_run      = (r_state != ST_IDLE);
  assign w_clear    = (w_state_nxt == ST_IDLE);
  assign w_end_tick = w_tick && (r_h == H_LAST) && (r_v == V_LAST);

  lcd_pix_clk_div #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (DIV_W)
  ) u_div (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_run     (w_run),
    .i_clear   (w_clear),
    .o_div_nxt (w_div_nxt),
    .o_tick    (w_tick),
    .o_dclk    (o_dclk)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: a stop request only takes effect at the end of a frame, and a
  // renewed run request cancels it without disturbing the raster.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (i_en) w_state_nxt = ST_RUN;
      ST_RUN:      if (!i_en) w_state_nxt = ST_STOPPING;
      ST_STOPPING: begin
        if (i_en)            w_state_nxt = ST_RUN;
        else if (w_end_tick) w_state_nxt = ST_IDLE;
      end
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Next raster position: advance on each pixel tick, park at (0,0) in IDLE.
  always_comb begin
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (w_state_nxt == ST_IDLE) begin
      w_h_nxt = '0;
      w_v_nxt = '0;
    end else if (w_tick) begin
      if (r_h == H_LAST) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v == V_LAST) ? '0 : r_v + V_W'(1);
      end else begin
        w_h_nxt = r_h + H_W'(1);
      end
    end
  end

  // Output decode of the next position; the address counts finished visible pixels.
  always_comb begin
    w_act   = (w_state_nxt != ST_IDLE);
    w_hs_on = w_act && (w_h_nxt < H_SYNC_E);
    w_vs_on = w_act && (w_v_nxt < V_SYNC_E);
    w_vis   = w_act && (w_h_nxt >= H_VIS_S) && (w_h_nxt < H_VIS_E) &&
              (w_v_nxt >= V_VIS_S) && (w_v_nxt < V_VIS_E);
    w_fs    = w_act && (w_h_nxt == '0) && (w_v_nxt == '0) && (w_div_nxt == '0);
    w_raddr_nxt = r_raddr;
    if (!w_act || w_fs) begin
      w_raddr_nxt = '0;
    end else if (w_tick && r_pix_active) begin
      w_raddr_nxt = r_raddr + ADDR_W'(1);
    end
  end

  // Position counters and registered panel outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h           <= '0;
      r_v           <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_disp        <= 1'b0;
      r_pix_active  <= 1'b0;
      r_raddr       <= '0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_h           <= w_h_nxt;
      r_v           <= w_v_nxt;
      r_hsync       <= w_hs_on ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_on ? VS_POL : ~VS_POL;
      r_de          <= DE_MODE ? w_vis : 1'b0;
      r_disp        <= w_act;
      r_pix_active  <= w_vis;
      r_raddr       <= w_raddr_nxt;
      r_frame_start <= w_fs;
      r_busy        <= w_act;
    end
  end

  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_de          = r_de;
  assign o_disp        = r_disp;
  assign o_pix_active  = r_pix_active;
  assign o_raddr       = r_raddr;
  assign o_raddr_max   = ADDR_W'(H_ACTIVE * V_ACTIVE);
  assign o_disp_width  = 16'(H_ACTIVE);
  assign o_frame_start = r_frame_start;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: one instance with default geometry, one with a
// tiny 10x6 raster (DE mode, active-high syncs, divide by 2).
module tb_lcd_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic d_rst, d_en, s_rst, s_en;

  // ---------------- DUTs ----------------
  logic        d_dclk, d_hsync, d_vsync, d_de, d_disp, d_pa, d_fs, d_busy;
  logic [16:0] d_raddr, d_raddr_max;
  logic [15:0] d_disp_width;

  lcd_timing_gen u_def (
    .i_clk         (clk),
    .i_rst         (d_rst),
    .i_en          (d_en),
    .o_dclk        (d_dclk),
    .o_hsync       (d_hsync),
    .o_vsync       (d_vsync),
    .o_de          (d_de),
    .o_disp        (d_disp),
    .o_pix_active  (d_pa),
    .o_raddr       (d_raddr),
    .o_raddr_max   (d_raddr_max),
    .o_disp_width  (d_disp_width),
    .o_frame_start (d_fs),
    .o_busy        (d_busy)
  );

  logic        s_dclk, s_hsync, s_vsync, s_de, s_disp, s_pa, s_fs, s_busy;
  logic [7:0]  s_raddr, s_raddr_max;
  logic [15:0] s_disp_width;

  lcd_timing_gen #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
    .CLK_DIV(2), .HS_POL(1'b1), .VS_POL(1'b1), .DE_MODE(1'b1), .ADDR_W(8)
  ) u_small (
    .i_clk         (clk),
    .i_rst         (s_rst),
    .i_en          (s_en),
    .o_dclk        (s_dclk),
    .o_hsync       (s_hsync),
    .o_vsync       (s_vsync),
    .o_de          (s_de),
    .o_disp        (s_disp),
    .o_pix_active  (s_pa),
    .o_raddr       (s_raddr),
    .o_raddr_max   (s_raddr_max),
    .o_disp_width  (s_disp_width),
    .o_frame_start (s_fs),
    .o_busy        (s_busy)
  );

  // Observation mux: sel=0 default instance, sel=1 small instance.
  logic        sel;
  logic        obs_dclk, obs_hs, obs_vs, obs_de, obs_disp, obs_pa, obs_fs, obs_busy;
  logic [16:0] obs_raddr;
  always_comb begin
    obs_dclk  = sel ? s_dclk  : d_dclk;
    obs_hs    = sel ? s_hsync : d_hsync;
    obs_vs    = sel ? s_vsync : d_vsync;
    obs_de    = sel ? s_de    : d_de;
    obs_disp  = sel ? s_disp  : d_disp;
    obs_pa    = sel ? s_pa    : d_pa;
    obs_fs    = sel ? s_fs    : d_fs;
    obs_busy  = sel ? s_busy  : d_busy;
    obs_raddr = sel ? {9'd0, s_raddr} : d_raddr;
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;
  int cur;

  typedef struct {
    int off;
    int fs;
    int hs;
    int vs;
    int de;
    int pa;
    int dclk;
    int raddr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(input int off, input int fs, input int hs, input int vs,
                               input int de, input int pa, input int dclk, input int raddr);
    vec_t v;
    v.off = off; v.fs = fs; v.hs = hs; v.vs = vs;
    v.de = de; v.pa = pa; v.dclk = dclk; v.raddr = raddr;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Step negedges until the cycle offset from the last frame start reaches off.
  task automatic advance_to(input int off);
    while (cur < off) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vt.size(); i++) begin
      advance_to(vt[i].off);
      chk($sformatf("%s fs@%0d", tag, vt[i].off),    int'(obs_fs),    vt[i].fs);
      chk($sformatf("%s hs@%0d", tag, vt[i].off),    int'(obs_hs),    vt[i].hs);
      chk($sformatf("%s vs@%0d", tag, vt[i].off),    int'(obs_vs),    vt[i].vs);
      chk($sformatf("%s de@%0d", tag, vt[i].off),    int'(obs_de),    vt[i].de);
      chk($sformatf("%s pa@%0d", tag, vt[i].off),    int'(obs_pa),    vt[i].pa);
      chk($sformatf("%s dclk@%0d", tag, vt[i].off),  int'(obs_dclk),  vt[i].dclk);
      chk($sformatf("%s raddr@%0d", tag, vt[i].off), int'(obs_raddr), vt[i].raddr);
    end
  endtask

  task automatic chk_idle(input string tag, input int hs_idle, input int vs_idle);
    chk({tag, " fs"},    int'(obs_fs),    0);
    chk({tag, " hs"},    int'(obs_hs),    hs_idle);
    chk({tag, " vs"},    int'(obs_vs),    vs_idle);
    chk({tag, " de"},    int'(obs_de),    0);
    chk({tag, " pa"},    int'(obs_pa),    0);
    chk({tag, " dclk"},  int'(obs_dclk),  0);
    chk({tag, " disp"},  int'(obs_disp),  0);
    chk({tag, " busy"},  int'(obs_busy),  0);
    chk({tag, " raddr"}, int'(obs_raddr), 0);
  endtask

  // Time limit in case anything stalls.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int stray;
    int busy_drop;
    int idle_bad;
    checks = 0; errors = 0; cur = 0;
    sel = 1'b0;
    d_rst = 1'b1; d_en = 1'b0;
    s_rst = 1'b1; s_en = 1'b0;

    // ===== default geometry =====
    repeat (3) @(negedge clk);
    d_en = 1'b1;
    @(negedge clk);
    chk_idle("def reset", 1, 1);
    chk("def raddr_max", int'(d_raddr_max), 130560);
    chk("def disp_width", int'(d_disp_width), 480);
    d_rst = 1'b0;
    @(negedge clk);
    cur = 0;
    vt.delete();
    //               off    fs hs vs de pa dclk raddr
    vt.push_back(mkv(0,     1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkv(1,     0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkv(2,     0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mkv(3,     0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mkv(4,     0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mkv(2123,  0, 1, 0, 0, 0, 1, 0));
    vt.push_back(mkv(2124,  0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkv(2128,  0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mkv(21236, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mkv(21240, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mkv(25659, 0, 1, 1, 0, 0, 1, 0));
    vt.push_back(mkv(25660, 0, 1, 1, 0, 1, 0, 0));
    vt.push_back(mkv(25664, 0, 1, 1, 0, 1, 0, 1));
    vt.push_back(mkv(27576, 0, 1, 1, 0, 1, 0, 479));
    vt.push_back(mkv(27579, 0, 1, 1, 0, 1, 1, 479));
    vt.push_back(mkv(27580, 0, 1, 1, 0, 0, 0, 480));
    run_vectors("def");
    d_rst = 1'b1;
    d_en  = 1'b0;

    // ===== small geometry: 10x6 pixels, 2 clocks per pixel =====
    sel = 1'b1;
    @(negedge clk);
    chk_idle("small reset", 0, 0);
    chk("small raddr_max", int'(s_raddr_max), 12);
    chk("small disp_width", int'(s_disp_width), 4);
    s_rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("small idle busy", int'(obs_busy), 0);
    s_en = 1'b1;
    @(negedge clk);
    cur = 0;
    vt.delete();
    //               off  fs hs vs de pa dclk raddr
    vt.push_back(mkv(0,   1, 1, 1, 0, 0, 0, 0));
    vt.push_back(mkv(1,   0, 1, 1, 0, 0, 1, 0));
    vt.push_back(mkv(2,   0, 1, 1, 0, 0, 0, 0));
    vt.push_back(mkv(4,   0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mkv(19,  0, 0, 1, 0, 0, 1, 0));
    vt.push_back(mkv(20,  0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mkv(46,  0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkv(48,  0, 0, 0, 1, 1, 0, 0));
    vt.push_back(mkv(55,  0, 0, 0, 1, 1, 1, 3));
    vt.push_back(mkv(56,  0, 0, 0, 0, 0, 0, 4));
    vt.push_back(mkv(68,  0, 0, 0, 1, 1, 0, 4));
    vt.push_back(mkv(70,  0, 0, 0, 1, 1, 0, 5));
    vt.push_back(mkv(94,  0, 0, 0, 1, 1, 0, 11));
    vt.push_back(mkv(96,  0, 0, 0, 0, 0, 0, 12));
    vt.push_back(mkv(110, 0, 0, 0, 0, 0, 0, 12));
    vt.push_back(mkv(119, 0, 0, 0, 0, 0, 1, 12));
    run_vectors("small");
    advance_to(120);
    chk("small frame period fs", int'(obs_fs), 1);
    chk("small raddr wrap", int'(obs_raddr), 0);

    // ----- stop request mid-frame: frame completes, then IDLE -----
    cur = 0;
    advance_to(30);
    s_en = 1'b0;
    advance_to(119);
    chk("stop busy before end", int'(obs_busy), 1);
    chk("stop disp before end", int'(obs_disp), 1);
    advance_to(120);
    chk_idle("stop idle", 0, 0);
    advance_to(125);
    chk("stop stays idle", int'(obs_busy), 0);

    // ----- stop request cancelled: frame spacing unchanged -----
    s_en = 1'b1;
    @(negedge clk);
    cur = 0;
    chk("restart fs", int'(obs_fs), 1);
    stray = 0;
    busy_drop = 0;
    while (cur < 120) begin
      @(negedge clk);
      cur++;
      if (cur == 30) s_en = 1'b0;
      if (cur == 60) s_en = 1'b1;
      if (cur < 120 && obs_fs) stray++;
      if (!obs_busy) busy_drop++;
    end
    chk("cancel fs at 120", int'(obs_fs), 1);
    chk("cancel stray fs", stray, 0);
    chk("cancel busy drop", busy_drop, 0);

    // ----- asynchronous reset in the visible area -----
    cur = 0;
    advance_to(50);
    chk("pre-reset pa", int'(obs_pa), 1);
    chk("pre-reset raddr", int'(obs_raddr), 1);
    #2;
    s_rst = 1'b1;
    #1;
    chk_idle("async reset", 0, 0);
    @(negedge clk);
    s_en  = 1'b0;
    s_rst = 1'b0;
    idle_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (obs_busy || obs_fs) idle_bad++;
    end
    chk("post-reset stays idle", idle_bad, 0);
    s_en = 1'b1;
    @(negedge clk);
    chk("post-reset fs", int'(obs_fs), 1);
    chk("post-reset hs", int'(obs_hs), 1);
    chk("post-reset vs", int'(obs_vs), 1);
    chk("post-reset raddr", int'(obs_raddr), 0);
    chk("post-reset busy", int'(obs_busy), 1);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
